dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  CPU presents a memory request.
REQ-006 SHALL have port req_ready  output  1  LSU can accept a request.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  DATA_W  store data, right-justified.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  extended load result; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  qualifies rsp_valid; illegal size.
REQ-015 SHALL have port mem_addr  output  ADDR_W  word-aligned RAM address (bits [1:0]=0).
REQ-016 SHALL have port mem_wen  output  1  RAM write enable.
REQ-017 SHALL have port mem_byte_en  output  4  RAM lane enables; bit i = byte lane i.
REQ-018 SHALL have port mem_wdata  output  DATA_W  lane-aligned store data.
REQ-019 SHALL have port mem_rdata  input  DATA_W  RAM read word, valid the cycle after mem_addr is presented.

Function
REQ-020 SHALL use states IDLE, ACC1, ACC2, FIN; req_ready=1 only in IDLE.
REQ-021 SHALL accept a request on req_valid&&req_ready, register all req_* fields, and go IDLE->ACC1.
REQ-022 SHALL classify a request as split when addr[1:0]+bytes>4: half at offset 3, or word at offset 1..3.
REQ-023 SHALL go ACC1->ACC2 if split, else ACC1->FIN; ACC2->FIN; FIN->IDLE.
REQ-024 SHALL in ACC1 drive mem_addr={addr[31:2],2'b00} and mem_byte_en=size mask<<addr[1:0], truncated to 4 bits.
REQ-025 SHALL in ACC2 drive mem_addr={addr[31:2],2'b00}+4, with wrap from 0xFFFFFFFC to 0x00000000, and mem_byte_en=the overflow lanes of the same mask.
REQ-026 SHALL place store bytes on the lanes they are enabled on: mem_wdata=wdata<<(8*addr[1:0]) in ACC1, wdata>>(8*(4-addr[1:0])) in ACC2.
REQ-027 SHALL assert mem_wen only in ACC1/ACC2 for stores; mem_wen=0 and mem_byte_en=0 in IDLE and FIN.
REQ-028 SHALL for a split load capture mem_rdata in ACC2 as the low word, then combine it with mem_rdata in FIN.
REQ-029 SHALL right-shift the assembled load bytes by 8*addr[1:0] and sign- or zero-extend per req_size/req_unsigned.
REQ-030 SHALL assert rsp_valid in FIN only; latency is 2 cycles after acceptance for unsplit requests and 3 cycles for split requests.
REQ-031 SHALL for req_size=11 make no memory access (ACC1 lanes=0, mem_wen=0), go directly to FIN, and respond with rsp_err=1 and rsp_rdata=0.
REQ-032 SHALL ignore req_valid outside IDLE; back-to-back requests are separated by at least one FIN cycle.

Reset
REQ-033 SHALL on rst go immediately to IDLE, including mid-access; the in-flight request is abandoned and the second half of a split store is never written.
REQ-034 SHALL hold these output values while rst is asserted: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wen=0, mem_byte_en=0, mem_addr=0, mem_wdata=0.

Structure
REQ-035 SHALL take the state enum, the size encodings (SZ_B, SZ_H, SZ_W), and lane-mask constants from shared package lsu_pkg.
REQ-036 SHALL place the combinational load shift/extend in one sub-module, lsu_load_extend.

Verification
REQ-037 Byte store: store 0xA5 to 0x13 -> one access, addr 0x10, byte_en 1000, wdata 0xA5000000, rsp_valid 2 cycles after acceptance.
REQ-038 Byte load: mem[0x10]=0x12F07F34, load byte from 0x12 -> signed 0xFFFFFFF0, unsigned 0x000000F0.
REQ-039 Split word load: mem[0x10]=0x44332211, mem[0x14]=0x88776655, load word from 0x11 -> accesses 0x10 then 0x14, rdata 0x55443322, rsp_valid 3 cycles after acceptance.
REQ-040 Split half store: store 0xBEEF at 0x17 -> first access 0x14, byte_en 1000, wdata 0xEF000000; second access 0x18, byte_en 0001, wdata 0x000000BE.
REQ-041 Reset mid-split: assert rst during ACC2 of a split store -> mem_wen=0 at once, second word unchanged, req_ready=1 after release.
REQ-042 Illegal size: request with req_size=11 -> no mem_wen, rsp_err=1 and rsp_rdata=0 with rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit:
// FSM states, request size encodings and byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    FIN  = 2'b11
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [3:0] LANES_B    = 4'b0001;
  localparam logic [3:0] LANES_H    = 4'b0011;
  localparam logic [3:0] LANES_W    = 4'b1111;
  localparam logic [3:0] LANES_NONE = 4'b0000;

  // Unshifted lane mask for a request size; the illegal size touches no lanes.
  function automatic logic [3:0] size_lanes(input logic [1:0] size);
    case (size)
      SZ_B:    return LANES_B;
      SZ_H:    return LANES_H;
      SZ_W:    return LANES_W;
      default: return LANES_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load alignment: pick the addressed bytes out of a pair of
// RAM words and sign- or zero-extend them to a full word.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [63:0] pair;
  logic [31:0] shifted;

  always_comb begin
    pair    = {hi_word, lo_word};
    shifted = 32'(pair >> {offset, 3'b000});
    data    = '0;
    case (size)
      SZ_B: data = is_unsigned ? {24'b0, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: data = is_unsigned ? {16'b0, shifted[15:0]}
                               : {{16{shifted[15]}}, shifted[15:0]};
      SZ_W: data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU and a word-wide, byte-enabled data RAM.
// Misaligned requests that cross a word boundary take two RAM accesses.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_byte_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e state, next_state;

  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] low_q;

  logic [1:0]        offset;
  logic              illegal;
  logic [7:0]        lanes;
  logic              split;
  logic [63:0]       wide_wdata;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] ext_lo;
  logic [DATA_W-1:0] ext_hi;
  logic [DATA_W-1:0] ext_data;

  // Lanes [3:0] belong to the first word, lanes [7:4] spill into the next one.
  assign offset     = addr_q[1:0];
  assign illegal    = (size_q == SZ_X);
  assign lanes      = {4'b0000, size_lanes(size_q)} << offset;
  assign split      = |lanes[7:4];
  assign wide_wdata = {32'b0, wdata_q} << {offset, 3'b000};
  assign base_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // In ACC2 the RAM is returning the first word of a split load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        low_q <= '0;
    else if (state == ACC2 && !we_q) low_q <= mem_rdata;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = ACC1;
      ACC1: next_state = split ? ACC2 : FIN;
      ACC2: next_state = FIN;
      FIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ext_lo = split ? low_q : mem_rdata;
  assign ext_hi = split ? mem_rdata : '0;

  lsu_load_extend u_load_extend (
    .lo_word     (ext_lo),
    .hi_word     (ext_hi),
    .offset      (offset),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_addr    = '0;
    mem_wen     = 1'b0;
    mem_byte_en = 4'b0000;
    mem_wdata   = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACC1: begin
        mem_addr    = base_addr;
        mem_byte_en = lanes[3:0];
        mem_wen     = we_q && !illegal;
        mem_wdata   = we_q ? wide_wdata[31:0] : '0;
      end
      ACC2: begin
        mem_addr    = base_addr + ADDR_W'(4);
        mem_byte_en = lanes[7:4];
        mem_wen     = we_q;
        mem_wdata   = we_q ? wide_wdata[63:32] : '0;
      end
      FIN: begin
        rsp_valid = 1'b1;
        rsp_err   = illegal;
        rsp_rdata = (!we_q && !illegal) ? ext_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a table of hand-computed requests against a
// small byte-enabled RAM, plus sequences for reset and held-valid behaviour.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram [16] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
    logic [31:0] a2;
    logic [3:0]  b2;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[$];

  dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_byte_en  (mem_byte_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // 64-byte RAM aliased over the address space; read data arrives one cycle later.
  always @(posedge clk) begin
    if (mem_wen)
      for (int k = 0; k < 4; k++)
        if (mem_byte_en[k]) ram[mem_addr[5:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= ram[mem_addr[5:2]];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                              input logic [31:0] a2, input logic [3:0] b2, input logic [31:0] w2);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat;
    v.a1 = a1; v.b1 = b1; v.w1 = w1; v.a2 = a2; v.b2 = b2; v.w2 = w2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cycles;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    checkOutput({v.name, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cycles    = 1;
    if (!v.err) checkOutput({v.name, ".addr1"}, mem_addr, v.a1);
    checkOutput({v.name, ".be1"}, 32'(mem_byte_en), 32'(v.b1));
    checkOutput({v.name, ".wen1"}, 32'(mem_wen), 32'(v.we && !v.err));
    if (v.we && !v.err) checkOutput({v.name, ".wdata1"}, mem_wdata, v.w1);
    while (!rsp_valid && cycles < 8) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 2 && !rsp_valid) begin
        checkOutput({v.name, ".addr2"}, mem_addr, v.a2);
        checkOutput({v.name, ".be2"}, 32'(mem_byte_en), 32'(v.b2));
        checkOutput({v.name, ".wen2"}, 32'(mem_wen), 32'(v.we));
        if (v.we) checkOutput({v.name, ".wdata2"}, mem_wdata, v.w2);
      end
    end
    checkOutput({v.name, ".latency"}, 32'(cycles), 32'(v.lat));
    checkOutput({v.name, ".rdata"}, rsp_rdata, v.rdata);
    checkOutput({v.name, ".err"}, 32'(rsp_err), 32'(v.err));
    @(posedge clk); #1;
    checkOutput({v.name, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    checkOutput({v.name, ".ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // name, we, size, uns, addr, wdata, rdata, err, lat, a1, be1, w1, a2, be2, w2
    vecs.push_back(mk("st_w10",    1, 2'b10, 0, 32'h10, 32'h12F07F34, 32'h0, 0, 2, 32'h10, 4'b1111, 32'h12F07F34, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_bs12",   0, 2'b00, 0, 32'h12, 32'h0, 32'hFFFFFFF0, 0, 2, 32'h10, 4'b0100, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_bu12",   0, 2'b00, 1, 32'h12, 32'h0, 32'h000000F0, 0, 2, 32'h10, 4'b0100, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_w14",    1, 2'b10, 0, 32'h14, 32'h88776655, 32'h0, 0, 2, 32'h14, 4'b1111, 32'h88776655, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_w10b",   1, 2'b10, 0, 32'h10, 32'h44332211, 32'h0, 0, 2, 32'h10, 4'b1111, 32'h44332211, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_w11",    0, 2'b10, 0, 32'h11, 32'h0, 32'h55443322, 0, 3, 32'h10, 4'b1110, 32'h0, 32'h14, 4'b0001, 32'h0));
    vecs.push_back(mk("st_b13",    1, 2'b00, 0, 32'h13, 32'hFFFFFFA5, 32'h0, 0, 2, 32'h10, 4'b1000, 32'hA5000000, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_bu13",   0, 2'b00, 1, 32'h13, 32'h0, 32'h000000A5, 0, 2, 32'h10, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_bs13",   0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 2, 32'h10, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_w10",    0, 2'b10, 0, 32'h10, 32'h0, 32'hA5332211, 0, 2, 32'h10, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_hs12",   0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFA533, 0, 2, 32'h10, 4'b1100, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_h17",    1, 2'b01, 0, 32'h17, 32'h0000BEEF, 32'h0, 0, 3, 32'h14, 4'b1000, 32'hEF000000, 32'h18, 4'b0001, 32'h000000BE));
    vecs.push_back(mk("ld_w14",    0, 2'b10, 0, 32'h14, 32'h0, 32'hEF776655, 0, 2, 32'h14, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_w18",    0, 2'b10, 0, 32'h18, 32'h0, 32'h000000BE, 0, 2, 32'h18, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_hu17",   0, 2'b01, 1, 32'h17, 32'h0, 32'h0000BEEF, 0, 3, 32'h14, 4'b1000, 32'h0, 32'h18, 4'b0001, 32'h0));
    vecs.push_back(mk("ld_hs17",   0, 2'b01, 0, 32'h17, 32'h0, 32'hFFFFBEEF, 0, 3, 32'h14, 4'b1000, 32'h0, 32'h18, 4'b0001, 32'h0));
    vecs.push_back(mk("ld_illeg",  0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 2, 32'h10, 4'b0000, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_illeg",  1, 2'b11, 0, 32'h11, 32'h12345678, 32'h0, 1, 2, 32'h10, 4'b0000, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_w10c",   0, 2'b10, 0, 32'h10, 32'h0, 32'hA5332211, 0, 2, 32'h10, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_w00",    1, 2'b10, 0, 32'h00, 32'h55667788, 32'h0, 0, 2, 32'h00, 4'b1111, 32'h55667788, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_wtop",   1, 2'b10, 0, 32'hFFFFFFFC, 32'h11223344, 32'h0, 0, 2, 32'hFFFFFFFC, 4'b1111, 32'h11223344, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_wwrap",  0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, 32'h77881122, 0, 3, 32'hFFFFFFFC, 4'b1100, 32'h0, 32'h00000000, 4'b0011, 32'h0));
    vecs.push_back(mk("st_hwrap",  1, 2'b01, 0, 32'hFFFFFFFF, 32'h0000CAFE, 32'h0, 0, 3, 32'hFFFFFFFC, 4'b1000, 32'hFE000000, 32'h00000000, 4'b0001, 32'h000000CA));
    vecs.push_back(mk("ld_w00",    0, 2'b10, 0, 32'h00, 32'h0, 32'h556677CA, 0, 2, 32'h00, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_butop",  0, 2'b00, 1, 32'hFFFFFFFF, 32'h0, 32'h000000FE, 0, 2, 32'hFFFFFFFC, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_hu11",   0, 2'b01, 1, 32'h11, 32'h0, 32'h00003322, 0, 2, 32'h10, 4'b0110, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("ld_bs10",   0, 2'b00, 0, 32'h10, 32'h0, 32'h00000011, 0, 2, 32'h10, 4'b0001, 32'h0, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_w18",    1, 2'b10, 0, 32'h18, 32'h00000000, 32'h0, 0, 2, 32'h18, 4'b1111, 32'h00000000, 32'h0, 4'b0, 32'h0));
    vecs.push_back(mk("st_w1c",    1, 2'b10, 0, 32'h1C, 32'hCAFEF00D, 32'h0, 0, 2, 32'h1C, 4'b1111, 32'hCAFEF00D, 32'h0, 4'b0, 32'h0));

    rst          = 1'b1;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    req_wdata    = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    checkOutput("reset.ready", 32'(req_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset.mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("reset.mem_byte_en", 32'(mem_byte_en), 32'd0);
    checkOutput("reset.mem_addr", mem_addr, 32'h0);
    checkOutput("reset.mem_wdata", mem_wdata, 32'h0);
    req_valid = 1'b0;
    rst       = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Split store abandoned by reset while its second word is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr  = 32'h19; req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_split.wen_acc2", 32'(mem_wen), 32'd1);
    checkOutput("rst_split.addr_acc2", mem_addr, 32'h1C);
    rst = 1'b1;
    #1;
    checkOutput("rst_split.wen_now", 32'(mem_wen), 32'd0);
    checkOutput("rst_split.be_now", 32'(mem_byte_en), 32'd0);
    checkOutput("rst_split.addr_now", mem_addr, 32'h0);
    checkOutput("rst_split.ready_now", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_split.ready_after", 32'(req_ready), 32'd1);
    checkOutput("rst_split.second_word", ram[7], 32'hCAFEF00D);
    checkOutput("rst_split.first_word", ram[6], 32'hB2C3D400);
    applyStimulus(mk("rst_ld_w1c", 0, 2'b10, 0, 32'h1C, 32'h0, 32'hCAFEF00D, 0, 2, 32'h1C, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));
    applyStimulus(mk("rst_ld_w18", 0, 2'b10, 0, 32'h18, 32'h0, 32'hB2C3D400, 0, 2, 32'h18, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0));

    // req_valid held high and the request changed while busy.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr  = 32'h1C; req_wdata = 32'h0;
    @(posedge clk); #1;
    checkOutput("hold.ready_acc1", 32'(req_ready), 32'd0);
    req_addr = 32'h10;
    @(posedge clk); #1;
    checkOutput("hold.valid_fin", 32'(rsp_valid), 32'd1);
    checkOutput("hold.ready_fin", 32'(req_ready), 32'd0);
    checkOutput("hold.rdata_fin", rsp_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    checkOutput("hold.ready_idle", 32'(req_ready), 32'd1);
    checkOutput("hold.valid_idle", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold.no_extra", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
